// File: rtl/adc_avg_pkg.sv
// Shared constants for the ADC sample averager and its integration with the
// pipelined-ADC correction stage: FSM state codes and default widths.
package adc_avg_pkg;

    // Corrected-sample width delivered by the correction stage.
    localparam int DW_DEFAULT = 13;

    // Width of the post-enable skip counter (SKIP is legal up to 63).
    localparam int SKIP_W = 6;

    // Acquisition FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small synchronous first-word-fall-through FIFO. The head word is visible on
// rdata whenever the FIFO is not empty; rdata reads as zero while empty.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo_fwft
    import adc_avg_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [DW-1:0]      wdata,
    input  logic               pop,
    output logic [DW-1:0]      rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_pop;
    logic               do_push;

    assign empty   = (level == '0);
    assign full    = (level == (FIFO_AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally; level carries one extra bit to tell full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_avg.sv
// ADC sample averager: drops the stale words the correction pipeline emits
// after each enable, block-averages 2^AVG_LOG2 words, and queues the averages
// in a FWFT FIFO with a sticky overflow flag.
module adc_sample_avg
    import adc_avg_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int AVG_LOG2 = 2,
    parameter int SKIP     = 6,
    parameter int FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DW-1:0]      din,
    output logic [DW-1:0]      dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               ovf,
    input  logic               clr_ovf
);

    localparam int AW = DW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);

    logic [1:0]        state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [CW-1:0]     smp_cnt;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     sum;
    logic [DW-1:0]     avg;
    logic              last;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              drop;

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale words, so the
    // sum including the current word can never wrap.
    assign sum  = acc + AW'(din);
    assign avg  = DW'(sum >> AVG_LOG2);
    assign last = (smp_cnt == LAST_CNT);
    assign push = en & (state == ST_ACC) & last;
    assign pop  = dout_valid & dout_ready;
    assign drop = push & full & ~pop;

    assign dout_valid = ~empty;

    // Skip/accumulate control; dropping en abandons any partial block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            smp_cnt  <= '0;
            acc      <= '0;
        end else if (!en) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            smp_cnt  <= '0;
            acc      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    skip_cnt <= SKIP_W'(SKIP);
                    state    <= (SKIP == 0) ? ST_ACC : ST_SKIP;
                end
                ST_SKIP: begin
                    skip_cnt <= skip_cnt - 1'b1;
                    if (skip_cnt <= SKIP_W'(1)) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (last) begin
                        acc     <= '0;
                        smp_cnt <= '0;
                    end else begin
                        acc     <= sum;
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .DW      (DW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (avg),
        .pop   (pop),
        .rdata (dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule
